// File: rtl/sized_data_memory.sv
// Byte/halfword/word data memory with configurable access latency, sign/zero load
// extension and misalignment detection behind a request/ready/done handshake.
module sized_data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] memaddr_i,
   input  logic [31:0] writedata_i,
   output logic        ready_o,
   output logic        done_o,
   output logic        misalign_o,
   output logic [31:0] memdata_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept, execute;

   logic            rd_q, wr_q, uns_q;
   logic [1:0]      size_q;
   logic [AW+1:0]   addr_q;
   logic [31:0]     wdata_q;

   logic            done_q, misalign_q;
   logic [31:0]     memdata_q;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [AW-1:0]   widx;
   logic [1:0]      off;
   logic            is_half, is_word, misalign;
   logic [31:0]     old_word, new_word, shifted, load_v, result;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic            do_write;

   // Only the word-index and byte-offset bits are stored; the rest alias away.
   logic            unused_addr_bits;
   assign unused_addr_bits = ^memaddr_i[31:AW+2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      execute = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               accept  = 1'b1;
               state_d = BUSY;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               execute = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      widx     = addr_q[AW+1:2];
      off      = addr_q[1:0];
      is_half  = (size_q == 2'b01);
      is_word  = size_q[1];
      misalign = (is_half && off[0]) || (is_word && (off != 2'b00));
      old_word = mem_q[widx];

      new_word = old_word;
      case (size_q)
         2'b00:   new_word[{off, 3'b000} +: 8]    = wdata_q[7:0];
         2'b01:   new_word[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: new_word = wdata_q;
      endcase

      shifted = old_word >> {off, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = off[1] ? old_word[31:16] : old_word[15:0];
      case (size_q)
         2'b00:   load_v = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   load_v = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
         default: load_v = old_word;
      endcase

      result   = (rd_q && !misalign) ? load_v : 32'b0;
      do_write = execute && wr_q && !misalign;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         memdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         done_q     <= execute;
         misalign_q <= execute && misalign;
         if (execute) memdata_q <= result;
         if (accept) begin
            rd_q    <= memread_i;
            wr_q    <= memwrite_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            addr_q  <= memaddr_i[AW+1:0];
            wdata_q <= writedata_i;
         end
      end
   end

   // NOTE: the array has no reset; a reset mid-access blocks the write because
   // do_write depends on state_q, which reset forces to IDLE.
   always_ff @(posedge clk_i) begin
      if (do_write) mem_q[widx] <= new_word;
   end

   assign ready_o    = (state_q == IDLE);
   assign done_o     = done_q;
   assign misalign_o = misalign_q;
   assign memdata_o  = memdata_q;

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed self-checking bench for sized_data_memory (DEPTH_WORDS=256, LATENCY=2).
module tb_sized_data_memory;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        memread_i = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] memaddr_i = '0;
   logic [31:0] writedata_i = '0;
   logic        ready_o, done_o, misalign_o;
   logic [31:0] memdata_o;

   int errors = 0;
   int checks = 0;

   sized_data_memory #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .memread_i(memread_i),
      .memwrite_i(memwrite_i), .size_i(size_i), .unsigned_i(unsigned_i),
      .memaddr_i(memaddr_i), .writedata_i(writedata_i), .ready_o(ready_o),
      .done_o(done_o), .misalign_o(misalign_o), .memdata_o(memdata_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one request from a sample point (#1 after an edge) and returns at
   // the done_o cycle with the result, misalign flag and cycles from acceptance.
   task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic mis, output int lat);
      int w = 0;
      while (!ready_o && w < 20) begin
         @(posedge clk_i); #1; w++;
      end
      if (!ready_o) check("ready_timeout", {31'b0, ready_o}, 32'd1);
      memread_i = rd; memwrite_i = wr; size_i = sz; unsigned_i = uns;
      memaddr_i = addr; writedata_i = wdata; req_i = 1'b1;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      memaddr_i = 32'hFFFF_FFFF; writedata_i = 32'hA5A5_A5A5;
      lat = 0;
      while (!done_o && lat < 20) begin
         @(posedge clk_i); #1; lat++;
      end
      if (!done_o) check("done_timeout", {31'b0, done_o}, 32'd1);
      data = memdata_o;
      mis  = misalign_o;
   endtask

   initial begin
      logic [31:0] d;
      logic        m;
      int          lat;
      int          acc[$];
      int          ndone;

      // Reset values
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_misalign", {31'b0, misalign_o}, 32'd0);
      check("rst_memdata", memdata_o, 32'h0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // Word store/load, latency 2
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, d, m, lat);
      check("store_latency", 32'(lat), 32'd2);
      check("store_misalign", {31'b0, m}, 32'd0);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, m, lat);
      check("load_word_10", d, 32'hDEADBEEF);
      check("load_latency", 32'(lat), 32'd2);

      // No-op completes with zero data
      access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, m, lat);
      check("noop_data", d, 32'h0);
      check("noop_latency", 32'(lat), 32'd2);

      // Byte and halfword stores with mixed loads
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, d, m, lat);
      access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, d, m, lat);
      access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h55558001, d, m, lat);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, m, lat);
      check("mixed_word", d, 32'h8001AB44);
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, d, m, lat);
      check("byte21_signed", d, 32'hFFFFFFAB);
      access(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, d, m, lat);
      check("byte21_unsigned", d, 32'h000000AB);
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, d, m, lat);
      check("byte20_signed_pos", d, 32'h00000044);
      access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, d, m, lat);
      check("half22_signed", d, 32'hFFFF8001);
      access(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, d, m, lat);
      check("half22_unsigned", d, 32'h00008001);
      access(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, d, m, lat);
      check("half20_signed", d, 32'hFFFFAB44);

      // Misalignment
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0BADF00D, d, m, lat);
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h05, 32'hFFFFFFFF, d, m, lat);
      check("mis_store_flag", {31'b0, m}, 32'd1);
      check("mis_store_done", {31'b0, done_o}, 32'd1);
      check("mis_store_data", d, 32'h0);
      access(1'b1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, d, m, lat);
      check("mis_half_flag", {31'b0, m}, 32'd1);
      check("mis_half_data", d, 32'h0);
      @(posedge clk_i); #1;
      check("misalign_one_cycle", {31'b0, misalign_o}, 32'd0);
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, d, m, lat);
      check("byte05_flag", {31'b0, m}, 32'd0);
      check("byte05_signed", d, 32'hFFFFFFF0);
      access(1'b1, 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, d, m, lat);
      check("word04_unchanged", d, 32'h0BADF00D);

      // Address aliasing
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, d, m, lat);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, d, m, lat);
      check("alias_400_000", d, 32'hCAFEF00D);

      // Both flags: old data returned, new data written
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, d, m, lat);
      access(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, d, m, lat);
      check("both_old_data", d, 32'h12345678);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, m, lat);
      check("both_followup", d, 32'h0);

      // req_i held high: acceptances LATENCY+1 cycles apart
      memread_i = 1'b1; memwrite_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
      memaddr_i = 32'h10; req_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (ready_o) acc.push_back(i);
         @(posedge clk_i); #1;
      end
      req_i = 1'b0;
      check("held_accept_count", 32'(acc.size()), 32'd4);
      for (int i = 1; i < acc.size(); i++)
         check("held_accept_gap", 32'(acc[i] - acc[i-1]), 32'd3);
      repeat (4) @(posedge clk_i);
      #1;

      // req_i pulse while busy is ignored
      memaddr_i = 32'h10; req_i = 1'b1;
      @(posedge clk_i); #1;
      check("busy_ready_low", {31'b0, ready_o}, 32'd0);
      memaddr_i = 32'h20;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         if (i == 0) req_i = 1'b0;
         if (done_o) ndone++;
      end
      check("busy_pulse_dones", 32'(ndone), 32'd1);
      check("busy_pulse_data", memdata_o, 32'hDEADBEEF);

      // Reset mid-access
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, d, m, lat);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, m, lat);
      memread_i = 1'b0; memwrite_i = 1'b1; size_i = 2'b10;
      memaddr_i = 32'h30; writedata_i = 32'h55555555; req_i = 1'b1;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      #1;
      check("midrst_ready", {31'b0, ready_o}, 32'd1);
      check("midrst_done", {31'b0, done_o}, 32'd0);
      check("midrst_memdata", memdata_o, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_i); #1;
         if (done_o) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, d, m, lat);
      check("midrst_no_write", d, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
